// File: rtl/cmd_pkg.sv
// Shared encodings for the command sequencer: instruction fields, opcodes,
// ALU operation codes, controller states and decode classes.
package cmd_pkg;

   localparam int unsigned OpcMsb = 7;
   localparam int unsigned OpcLsb = 4;
   localparam int unsigned DstMsb = 3;
   localparam int unsigned DstLsb = 2;
   localparam int unsigned SrcMsb = 1;
   localparam int unsigned SrcLsb = 0;

   localparam logic [3:0] OpNop = 4'h0;
   localparam logic [3:0] OpMov = 4'h1;
   localparam logic [3:0] OpAdd = 4'h2;
   localparam logic [3:0] OpSub = 4'h3;
   localparam logic [3:0] OpAnd = 4'h4;
   localparam logic [3:0] OpOr  = 4'h5;
   localparam logic [3:0] OpLdi = 4'h6;
   localparam logic [3:0] OpIn  = 4'h7;
   localparam logic [3:0] OpJmp = 4'h8;
   localparam logic [3:0] OpJz  = 4'h9;
   localparam logic [3:0] OpHlt = 4'hF;

   localparam logic [2:0] AluPassB = 3'b000;
   localparam logic [2:0] AluAdd   = 3'b001;
   localparam logic [2:0] AluSub   = 3'b010;
   localparam logic [2:0] AluAnd   = 3'b011;
   localparam logic [2:0] AluOr    = 3'b100;

   typedef enum logic [3:0] {
      StIdle,
      StFetch,
      StFetchW,
      StDecode,
      StRdB,
      StImmF,
      StImmW,
      StExec,
      StWaitIn,
      StInWr,
      StHalt
   } state_e;

   // Where DECODE sends an instruction; two-byte forms are split off separately.
   typedef enum logic [2:0] {
      ClsNop,
      ClsHalt,
      ClsIn,
      ClsExec,
      ClsBranch
   } cls_e;

endpackage

// File: rtl/cmd_decode.sv
// Combinational opcode decoder: next-state class, ALU op, flag-update enable
// and two-byte flag. Reserved opcodes decode as NOP.
module cmd_decode
   import cmd_pkg::*;
(
   input  logic [3:0] i_opcode,
   output cls_e       o_cls,
   output logic [2:0] o_alu_op,
   output logic       o_flag_en,
   output logic       o_two_byte
);

   always_comb begin
      o_cls      = ClsNop;
      o_alu_op   = AluPassB;
      o_flag_en  = 1'b0;
      o_two_byte = 1'b0;
      case (i_opcode)
         OpMov: o_cls = ClsExec;
         OpAdd: begin
            o_cls     = ClsExec;
            o_alu_op  = AluAdd;
            o_flag_en = 1'b1;
         end
         OpSub: begin
            o_cls     = ClsExec;
            o_alu_op  = AluSub;
            o_flag_en = 1'b1;
         end
         OpAnd: begin
            o_cls     = ClsExec;
            o_alu_op  = AluAnd;
            o_flag_en = 1'b1;
         end
         OpOr: begin
            o_cls     = ClsExec;
            o_alu_op  = AluOr;
            o_flag_en = 1'b1;
         end
         OpLdi: begin
            o_cls      = ClsExec;
            o_two_byte = 1'b1;
         end
         OpIn:  o_cls = ClsIn;
         OpJmp, OpJz: begin
            o_cls      = ClsBranch;
            o_two_byte = 1'b1;
         end
         OpHlt: o_cls = ClsHalt;
         OpNop: o_cls = ClsNop;
         default: o_cls = ClsNop;
      endcase
   end

endmodule

// File: rtl/cmd_sequencer.sv
// Multi-cycle command sequencer: fetches from a synchronous ROM and drives the
// register file control pins and ALU operands for each instruction.
module cmd_sequencer
   import cmd_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic [7:0] rom_addr,
   input  logic [7:0] rom_data,
   input  logic       in_valid,
   output logic       in_ack,
   output logic [1:0] RA,
   output logic       wr,
   output logic       rd,
   output logic       enact,
   output logic [1:0] res_dest,
   input  logic [7:0] X,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   output logic [2:0] alu_op,
   input  logic       alu_zero,
   output logic       busy,
   output logic       halted
);

   state_e     r_state, w_state_d;
   logic [7:0] r_pc, w_pc_d;
   logic [7:0] r_ir, w_ir_d;
   logic [7:0] r_rom_addr, w_rom_addr_d;
   logic [7:0] r_alu_a, w_alu_a_d;
   logic [7:0] r_alu_b, w_alu_b_d;
   logic       r_z, w_z_d;

   logic [3:0] w_opc;
   logic [1:0] w_dst;
   logic [1:0] w_src;
   cls_e       w_cls;
   logic [2:0] w_dec_alu_op;
   logic       w_flag_en;
   logic       w_two_byte;

   assign w_opc = r_ir[OpcMsb:OpcLsb];
   assign w_dst = r_ir[DstMsb:DstLsb];
   assign w_src = r_ir[SrcMsb:SrcLsb];

   cmd_decode u_decode (
      .i_opcode   (w_opc),
      .o_cls      (w_cls),
      .o_alu_op   (w_dec_alu_op),
      .o_flag_en  (w_flag_en),
      .o_two_byte (w_two_byte)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= StIdle;
         r_pc       <= 8'h00;
         r_ir       <= 8'h00;
         r_rom_addr <= 8'h00;
         r_alu_a    <= 8'h00;
         r_alu_b    <= 8'h00;
         r_z        <= 1'b0;
      end else begin
         r_state    <= w_state_d;
         r_pc       <= w_pc_d;
         r_ir       <= w_ir_d;
         r_rom_addr <= w_rom_addr_d;
         r_alu_a    <= w_alu_a_d;
         r_alu_b    <= w_alu_b_d;
         r_z        <= w_z_d;
      end
   end

   // Register-file pins decode from state, so reset drops wr/rd immediately.
   always_comb begin
      w_state_d = r_state;
      w_pc_d    = r_pc;
      w_ir_d    = r_ir;
      w_alu_a_d = r_alu_a;
      w_alu_b_d = r_alu_b;
      w_z_d     = r_z;
      RA        = 2'b00;
      wr        = 1'b0;
      rd        = 1'b0;
      in_ack    = 1'b0;
      alu_op    = AluPassB;

      unique case (r_state)
         StIdle, StHalt: begin
            if (start) begin
               w_state_d = StFetch;
               w_pc_d    = 8'h00;
               w_z_d     = 1'b0;
            end
         end
         StFetch: w_state_d = StFetchW;
         StFetchW: begin
            w_ir_d    = rom_data;
            w_pc_d    = r_pc + 8'd1;
            w_state_d = StDecode;
         end
         StDecode: begin
            RA        = w_dst;
            w_alu_a_d = X;
            unique case (w_cls)
               ClsNop:  w_state_d = StFetch;
               ClsHalt: w_state_d = StHalt;
               ClsIn:   w_state_d = StWaitIn;
               default: w_state_d = w_two_byte ? StImmF : StRdB;
            endcase
         end
         StRdB: begin
            RA        = w_src;
            w_alu_b_d = X;
            w_state_d = StExec;
         end
         StImmF: w_state_d = StImmW;
         StImmW: begin
            w_pc_d = r_pc + 8'd1;
            // The immediate goes straight to its consumer: pc for branches, alu_b for LDI.
            if (w_cls == ClsBranch) begin
               if ((w_opc == OpJmp) || r_z) begin
                  w_pc_d = rom_data;
               end
               w_state_d = StFetch;
            end else begin
               w_alu_b_d = rom_data;
               w_state_d = StExec;
            end
         end
         StExec: begin
            RA     = w_dst;
            wr     = 1'b1;
            rd     = 1'b1;
            alu_op = w_dec_alu_op;
            if (w_flag_en) begin
               w_z_d = alu_zero;
            end
            w_state_d = StFetch;
         end
         StWaitIn: begin
            RA = w_dst;
            if (in_valid) begin
               w_state_d = StInWr;
            end
         end
         StInWr: begin
            RA        = w_dst;
            rd        = 1'b1;
            in_ack    = 1'b1;
            w_state_d = StFetch;
         end
         default: w_state_d = StIdle;
      endcase
   end

   // ROM address is loaded on entry to a fetch state so data is ready one cycle later.
   always_comb begin
      w_rom_addr_d = r_rom_addr;
      if ((w_state_d == StFetch) || (w_state_d == StImmF)) begin
         w_rom_addr_d = w_pc_d;
      end
   end

   assign rom_addr = r_rom_addr;
   assign alu_a    = r_alu_a;
   assign alu_b    = r_alu_b;
   assign enact    = 1'b1;
   assign res_dest = 2'b00;
   assign busy     = (r_state != StIdle) && (r_state != StHalt);
   assign halted   = (r_state == StHalt);

endmodule

// File: tb/tb_cmd_sequencer.sv
// Self-checking bench: ROM, register file and ALU environment models plus an
// instruction-level reference model for random programs.
module tb_cmd_sequencer;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] rom_addr;
   logic [7:0] rom_data;
   logic       in_valid;
   logic       in_ack;
   logic [1:0] RA;
   logic       wr;
   logic       rd;
   logic       enact;
   logic [1:0] res_dest;
   logic [7:0] X;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [2:0] alu_op;
   logic       alu_zero;
   logic       busy;
   logic       halted;

   logic [7:0] data_in;
   logic [7:0] alu_res;
   logic [7:0] rom [0:255];
   logic [7:0] rf [0:3];
   logic [7:0] rf_init [0:3];
   logic [7:0] m_rf [0:3];
   logic       rf_load;

   int n_checks;
   int n_fail;

   localparam logic [36:0] ResetVec = {8'h00, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 8'h00, 8'h00,
                                       3'b000, 1'b0, 1'b0, 1'b0};

   cmd_sequencer dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .rom_addr (rom_addr),
      .rom_data (rom_data),
      .in_valid (in_valid),
      .in_ack   (in_ack),
      .RA       (RA),
      .wr       (wr),
      .rd       (rd),
      .enact    (enact),
      .res_dest (res_dest),
      .X        (X),
      .alu_a    (alu_a),
      .alu_b    (alu_b),
      .alu_op   (alu_op),
      .alu_zero (alu_zero),
      .busy     (busy),
      .halted   (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) rom_data <= rom[rom_addr];

   always_comb begin
      case (alu_op)
         3'b001:  alu_res = alu_a + alu_b;
         3'b010:  alu_res = alu_a - alu_b;
         3'b011:  alu_res = alu_a & alu_b;
         3'b100:  alu_res = alu_a | alu_b;
         default: alu_res = alu_b;
      endcase
   end
   assign alu_zero = (alu_res == 8'h00);

   // Register file: negedge-sampled, mode selected by wr/rd.
   always @(negedge clk) begin
      if (rf_load) begin
         for (int i = 0; i < 4; i++) rf[i] <= rf_init[i];
      end else if (wr && rd) begin
         rf[RA] <= alu_res;
      end else if (!wr && rd) begin
         rf[RA] <= data_in;
      end
      X <= rf[RA];
   end

   task automatic clear_rom();
      for (int i = 0; i < 256; i++) rom[i] = 8'hF0;
   endtask

   task automatic load_regs(input logic [7:0] r0, input logic [7:0] r1,
                            input logic [7:0] r2, input logic [7:0] r3);
      rf_init[0] = r0; rf_init[1] = r1; rf_init[2] = r2; rf_init[3] = r3;
      m_rf[0] = r0; m_rf[1] = r1; m_rf[2] = r2; m_rf[3] = r3;
      @(posedge clk);
      rf_load = 1'b1;
      @(negedge clk);
      #1 rf_load = 1'b0;
   endtask

   task automatic do_reset();
      start = 1'b0;
      in_valid = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Cycles counted from the posedge that samples start until halted is seen.
   task automatic run_prog(output int cyc);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      cyc = 0;
      while (!halted && cyc < 1000) begin
         @(posedge clk);
         #1 cyc++;
      end
   endtask

   // Instruction-level reference: executes the ROM image on m_rf.
   task automatic model_run(output int cyc, output logic [7:0] hpc);
      logic [7:0] pc, ins, imm, res;
      logic [1:0] d, s;
      logic       z;
      bit         done;
      pc = 8'h00; z = 1'b0; cyc = 0; hpc = 8'h00; done = 1'b0;
      for (int step = 0; step < 1000 && !done; step++) begin
         ins = rom[pc];
         pc  = pc + 8'd1;
         d   = ins[3:2];
         s   = ins[1:0];
         case (ins[7:4])
            4'h1: begin m_rf[d] = m_rf[s]; cyc += 5; end
            4'h2, 4'h3, 4'h4, 4'h5: begin
               case (ins[7:4])
                  4'h2:    res = m_rf[d] + m_rf[s];
                  4'h3:    res = m_rf[d] - m_rf[s];
                  4'h4:    res = m_rf[d] & m_rf[s];
                  default: res = m_rf[d] | m_rf[s];
               endcase
               m_rf[d] = res;
               z = (res == 8'h00);
               cyc += 5;
            end
            4'h6: begin imm = rom[pc]; pc = pc + 8'd1; m_rf[d] = imm; cyc += 6; end
            4'h8: begin imm = rom[pc]; pc = imm; cyc += 5; end
            4'h9: begin imm = rom[pc]; pc = z ? imm : pc + 8'd1; cyc += 5; end
            4'hF: begin hpc = pc - 8'd1; cyc += 3; done = 1'b1; end
            default: cyc += 3;
         endcase
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if ({rom_addr, RA, wr, rd, enact, res_dest, alu_a, alu_b, alu_op, in_ack, busy, halted}
          !== ResetVec) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h expected %h",
                  {rom_addr, RA, wr, rd, enact, res_dest, alu_a, alu_b, alu_op, in_ack, busy,
                   halted}, ResetVec);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_ldi_add();
      int cyc;
      do_reset();
      clear_rom();
      rom[0] = 8'h64; rom[1] = 8'h05; rom[2] = 8'h68; rom[3] = 8'h03;
      rom[4] = 8'h26; rom[5] = 8'hF0;
      load_regs(8'h00, 8'h00, 8'h00, 8'h00);
      run_prog(cyc);
      n_checks++;
      if (cyc !== 20) begin
         n_fail++; $display("FAIL ldi_add_cycles: got %0d expected 20", cyc);
      end
      n_checks++;
      if (rf[1] !== 8'h08) begin
         n_fail++; $display("FAIL ldi_add_r1: got %h expected 08", rf[1]);
      end
      n_checks++;
      if (rf[2] !== 8'h03) begin
         n_fail++; $display("FAIL ldi_add_r2: got %h expected 03", rf[2]);
      end
      n_checks++;
      if (rom_addr !== 8'h05 || busy !== 1'b0) begin
         n_fail++; $display("FAIL ldi_add_halt: rom_addr %h busy %b expected 05 0", rom_addr, busy);
      end
   endtask

   task automatic test_jz();
      int cyc;
      do_reset();
      clear_rom();
      rom[0] = 8'h35; rom[1] = 8'h90; rom[2] = 8'h10; rom[3] = 8'hF0; rom[16] = 8'hF0;
      load_regs(8'h00, 8'h5A, 8'h00, 8'h00);
      run_prog(cyc);
      n_checks++;
      if (cyc !== 13 || rom_addr !== 8'h10) begin
         n_fail++; $display("FAIL jz_taken: cycles %0d rom_addr %h expected 13 10", cyc, rom_addr);
      end
      n_checks++;
      if (rf[1] !== 8'h00) begin
         n_fail++; $display("FAIL jz_taken_r1: got %h expected 00", rf[1]);
      end
      rom[0] = 8'h36;
      load_regs(8'h00, 8'h05, 8'h03, 8'h00);
      run_prog(cyc);
      n_checks++;
      if (cyc !== 13 || rom_addr !== 8'h03) begin
         n_fail++; $display("FAIL jz_not_taken: cycles %0d rom_addr %h expected 13 03", cyc, rom_addr);
      end
      n_checks++;
      if (rf[1] !== 8'h02) begin
         n_fail++; $display("FAIL jz_not_taken_r1: got %h expected 02", rf[1]);
      end
   endtask

   task automatic test_in();
      int cyc, acks, idle_cnt;
      do_reset();
      clear_rom();
      rom[0] = 8'h7C; rom[1] = 8'hF0;
      load_regs(8'h00, 8'h00, 8'h00, 8'h00);
      data_in = 8'h3C;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      acks = 0; idle_cnt = 0; cyc = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         if (!busy) idle_cnt++;
         if (in_ack) acks++;
      end
      @(negedge clk);
      data_in  = 8'hA5;
      in_valid = 1'b1;
      while (!halted && cyc < 50) begin
         @(posedge clk);
         #1 cyc++;
         if (in_ack) begin
            acks++;
            in_valid = 1'b0;
         end
         if (!halted && !busy) idle_cnt++;
      end
      in_valid = 1'b0;
      n_checks++;
      if (idle_cnt !== 0) begin
         n_fail++; $display("FAIL in_busy: busy low for %0d cycles expected 0", idle_cnt);
      end
      n_checks++;
      if (acks !== 1) begin
         n_fail++; $display("FAIL in_ack_count: got %0d expected 1", acks);
      end
      n_checks++;
      if (rf[3] !== 8'hA5) begin
         n_fail++; $display("FAIL in_r3: got %h expected a5", rf[3]);
      end
      n_checks++;
      if (halted !== 1'b1 || rom_addr !== 8'h01) begin
         n_fail++; $display("FAIL in_halt: halted %b rom_addr %h expected 1 01", halted, rom_addr);
      end
   endtask

   task automatic test_pc_wrap();
      int cyc;
      do_reset();
      clear_rom();
      rom[0] = 8'h80; rom[1] = 8'hFF; rom[255] = 8'h64;
      load_regs(8'h00, 8'h00, 8'h00, 8'h00);
      run_prog(cyc);
      n_checks++;
      if (cyc !== 14 || rom_addr !== 8'h01) begin
         n_fail++; $display("FAIL pc_wrap: cycles %0d rom_addr %h expected 14 01", cyc, rom_addr);
      end
      n_checks++;
      if (rf[1] !== 8'h80) begin
         n_fail++; $display("FAIL pc_wrap_r1: got %h expected 80", rf[1]);
      end
   endtask

   task automatic test_reset_mid_exec();
      int cyc;
      do_reset();
      clear_rom();
      rom[0] = 8'h21; rom[1] = 8'hF0;
      load_regs(8'h11, 8'h22, 8'h00, 8'h00);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      n_checks++;
      if (wr !== 1'b1 || rd !== 1'b1 || alu_op !== 3'b001) begin
         n_fail++; $display("FAIL mid_exec_reached: wr %b rd %b alu_op %b expected 1 1 001",
                            wr, rd, alu_op);
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if ({rom_addr, RA, wr, rd, enact, res_dest, alu_a, alu_b, alu_op, in_ack, busy, halted}
          !== ResetVec) begin
         n_fail++;
         $display("FAIL mid_reset_outputs: got %h expected %h",
                  {rom_addr, RA, wr, rd, enact, res_dest, alu_a, alu_b, alu_op, in_ack, busy,
                   halted}, ResetVec);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      n_checks++;
      if (rf[0] !== 8'h11) begin
         n_fail++; $display("FAIL mid_reset_r0: got %h expected 11", rf[0]);
      end
      run_prog(cyc);
      n_checks++;
      if (cyc !== 8 || rf[0] !== 8'h33 || rom_addr !== 8'h01) begin
         n_fail++; $display("FAIL mid_reset_rerun: cycles %0d r0 %h rom_addr %h expected 8 33 01",
                            cyc, rf[0], rom_addr);
      end
   endtask

   task automatic test_nop_start_busy();
      int cyc, writes;
      logic [7:0] r0, r1, r2, r3;
      do_reset();
      clear_rom();
      rom[0] = 8'hB5; rom[1] = 8'hF0;
      r0 = 8'($urandom); r1 = 8'($urandom); r2 = 8'($urandom); r3 = 8'($urandom);
      load_regs(r0, r1, r2, r3);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      cyc = 0; writes = 0;
      while (!halted && cyc < 100) begin
         @(posedge clk);
         #1 cyc++;
         if (cyc == 1) start = 1'b1;
         if (cyc == 2) start = 1'b0;
         if (wr || rd) writes++;
      end
      start = 1'b0;
      n_checks++;
      if (cyc !== 6 || rom_addr !== 8'h01) begin
         n_fail++; $display("FAIL nop_start: cycles %0d rom_addr %h expected 6 01", cyc, rom_addr);
      end
      n_checks++;
      if (writes !== 0) begin
         n_fail++; $display("FAIL nop_writes: %0d write cycles expected 0", writes);
      end
      n_checks++;
      if ({rf[0], rf[1], rf[2], rf[3]} !== {r0, r1, r2, r3}) begin
         n_fail++; $display("FAIL nop_regs: got %h expected %h",
                            {rf[0], rf[1], rf[2], rf[3]}, {r0, r1, r2, r3});
      end
   endtask

   task automatic test_random_programs();
      int         cyc, exp_cyc, n, kind;
      logic [7:0] a, hpc;
      for (int t = 0; t < 20; t++) begin
         clear_rom();
         a = 8'h00;
         n = int'($urandom_range(4, 10));
         for (int k = 0; k < n; k++) begin
            kind = int'($urandom_range(0, 9));
            case (kind)
               0: rom[a] = {4'h0, 4'($urandom)};
               1: rom[a] = {4'($urandom_range(10, 14)), 4'($urandom)};
               2: rom[a] = {4'h1, 4'($urandom)};
               3, 4, 5, 6: rom[a] = {4'($urandom_range(2, 5)), 4'($urandom)};
               7: begin rom[a] = {4'h6, 4'($urandom)}; a++; rom[a] = 8'($urandom); end
               8: begin rom[a] = 8'h90; a++; rom[a] = 8'h40; end
               default: begin rom[a] = 8'h80; a++; rom[a] = 8'h40; end
            endcase
            a++;
         end
         rom[a] = 8'hF0;
         rom[64] = {4'($urandom_range(2, 5)), 4'($urandom)};
         rom[65] = 8'hF0;
         load_regs(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
         model_run(exp_cyc, hpc);
         run_prog(cyc);
         n_checks++;
         if (cyc !== exp_cyc || rom_addr !== hpc) begin
            n_fail++; $display("FAIL rand%0d_flow: cycles %0d rom_addr %h expected %0d %h",
                               t, cyc, rom_addr, exp_cyc, hpc);
         end
         for (int r = 0; r < 4; r++) begin
            n_checks++;
            if (rf[r] !== m_rf[r]) begin
               n_fail++; $display("FAIL rand%0d_r%0d: got %h expected %h", t, r, rf[r], m_rf[r]);
            end
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      data_in  = 8'h00;
      rf_load  = 1'b0;
      clear_rom();
      test_reset();
      test_ldi_add();
      test_jz();
      test_in();
      test_pc_wrap();
      test_reset_mid_exec();
      test_nop_start_busy();
      test_random_programs();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
